arbiter_wrr_lock: RTL

Weighted round-robin arbiter with grant lock. It shares one transaction-oriented resource (bus port, memory channel) among N requesters. A grant is registered and held across whole transactions. Each winner may complete up to a programmable number of consecutive transactions (its weight) before the round-robin HEAD rotates. It sits between requester ports and the shared-resource mux/controller, and drives the mux select directly.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_rr_pick.sv | 28 ++
 rtl/arbiter_wrr_lock.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family.
// Provides the arbiter state enum and a one-hot to binary index converter
// sized for up to 16 requesters.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Converts a one-hot (or zero) vector of up to 16 bits into its bit index.
  // ORing the indices of set bits is exact for one-hot input and yields 0 for
  // an all-zero vector, which is the idle id.
  function automatic logic [3:0] onehot_to_index(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational circular priority picker.
// Returns a one-hot grant for the first set bit of req found by scanning
// upward from position head and wrapping past N-1 to 0. The request vector
// is rotated so that head lands at bit 0, the lowest set bit is isolated,
// and the result is rotated back.
module arb_rr_pick #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] head,
  output logic [N-1:0]    grant,
  output logic            any
);

  logic [N-1:0] req_rot;
  logic [N-1:0] gnt_rot;

  // Rotate right by head, keep the lowest set bit, rotate back left by head.
  always_comb begin
    req_rot = N'({req, req} >> head);
    gnt_rot = req_rot & (-req_rot);
    grant   = N'(({gnt_rot, gnt_rot} << head) >> N);
  end

  assign any = |req;

endmodule

// File: rtl/arbiter_wrr_lock.sv
// Weighted round-robin arbiter with grant lock.
// A registered one-hot grant is held across whole transactions; the winner
// may complete up to its weight in transactions (weight 0 counts as 1)
// before the round-robin head moves past it. Releases also happen when the
// granted requester withdraws its request.
// Optional macro ARB_WRR_TIMEOUT_EN adds a grant watchdog that forces a
// release after TIMEOUT cycles without a completed transaction and pulses
// o_timeout alongside the release.
module arbiter_wrr_lock
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [N-1:0]            i_req,
  input  logic                    i_done,
  input  logic [N*WEIGHT_W-1:0]   i_weight,
  output logic [N-1:0]            o_grant,
  output logic                    o_grant_valid,
  output logic [$clog2(N)-1:0]    o_grant_id,
  output logic                    o_timeout
);

  localparam int ID_W = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_param_check
    $error("arbiter_wrr_lock: N must be 2..16 and TIMEOUT at least 1");
  end

  arb_state_t          state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     head_q, pick_head;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] pick_weight;
  logic [N-1:0]        pick_grant;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic                granted_req;
  logic                release_now;
  logic                timeout_hit;
  logic                load;

  assign granted_req = i_req[id_q];

  // Release when the last credited transaction completes, when the owner
  // withdraws, or when the watchdog fires.
  always_comb begin
    release_now = (state_q == GRANT) &&
                  ((i_done && (credit_q == WEIGHT_W'(1))) || !granted_req || timeout_hit);
    pick_head   = head_q;
    if (release_now) begin
      pick_head = (id_q == ID_W'(N - 1)) ? '0 : id_q + ID_W'(1);
    end
  end

  arb_rr_pick #(
    .N (N)
  ) u_pick (
    .req   (i_req),
    .head  (pick_head),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign pick_id = ID_W'(onehot_to_index(16'(pick_grant)));

  // Select the weight field of the requester about to be granted.
  always_comb begin
    pick_weight = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_grant[k]) begin
        pick_weight = pick_weight | i_weight[k*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Next-state logic: load a new grant, hold it while spending credit, or
  // drop back to idle when nobody else is asking.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    id_d     = id_q;
    credit_d = credit_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        load = pick_any;
      end
      GRANT: begin
        if (release_now) begin
          if (pick_any) begin
            load = 1'b1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            id_d     = '0;
            credit_d = '0;
          end
        end else if (i_done) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: ;
    endcase
    if (load) begin
      state_d  = GRANT;
      grant_d  = pick_grant;
      id_d     = pick_id;
      credit_d = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
    end
  end

  // Grant, credit and round-robin head registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      head_q   <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      head_q   <= pick_head;
      credit_q <= credit_d;
    end
  end

`ifdef ARB_WRR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_q;

  assign timeout_hit = (state_q == GRANT) && (wd_cnt_q == CNT_W'(TIMEOUT));

  // Watchdog counts grant cycles without a completed transaction.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt_q <= '0;
    end else if ((state_q != GRANT) || release_now || i_done) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  // Timeout pulse is registered so it lines up with the forced release.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign o_grant       = grant_q;
  assign o_grant_valid = |grant_q;
  assign o_grant_id    = id_q;

endmodule
